// File: rtl/btn_led_pkg.sv
// Shared mode encodings and default timing constants for the button/LED controller.
package btn_led_pkg;

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_MOM    = 2'b01;
   localparam logic [1:0] MODE_BLINK  = 2'b10;
   localparam logic [1:0] MODE_OFF    = 2'b11;

   localparam int DEF_DB_CYCLES = 1_000_000;
   localparam int DEF_BLINK_DIV = 25_000_000;
   localparam int DEF_LONG_CYC  = 200_000_000;

   // Modes in which a press flips the latched channel state.
   function automatic logic mode_toggles(input logic [1:0] m);
      return (m == MODE_TOGGLE) || (m == MODE_BLINK);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-channel 2-FF synchroniser plus counter debouncer with a registered rising-edge pulse.
module btn_debounce
#(
   parameter int DB_CYCLES = 4
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_pulse_o
);

   localparam int DB_W = $clog2(DB_CYCLES);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic            rise_q, rise_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   // The counter only advances on consecutive mismatching cycles; any agreement restarts it.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
            stable_d = ~stable_q;
            rise_d   = ~stable_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o     = stable_q;
   assign rise_pulse_o = rise_q;

endmodule

// File: rtl/btn_led_ctrl.sv
// N-channel button-to-LED controller: debounce, press pulses, per-channel LED mode, press count.
// Optional long-press detection is compiled in with BTN_LONG_PRESS_EN.
module btn_led_ctrl
   import btn_led_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int DB_CYCLES = DEF_DB_CYCLES,
   parameter int BLINK_DIV = DEF_BLINK_DIV,
   parameter int LONG_CYC  = DEF_LONG_CYC,
   parameter int CNT_W     = 8
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_CH-1:0]     btn_i,
   input  logic [2*N_CH-1:0]   mode_i,
   output logic [N_CH-1:0]     led_o,
   output logic [N_CH-1:0]     press_o,
   output logic [N_CH-1:0]     long_press_o,
   output logic [CNT_W-1:0]    press_total_o
);

   localparam int BLK_W = $clog2(BLINK_DIV);

   if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("btn_led_ctrl: N_CH out of range");
   end
   if (DB_CYCLES < 2 || BLINK_DIV < 2 || LONG_CYC < 1) begin : g_bad_cyc
      $error("btn_led_ctrl: cycle parameter too small");
   end

   logic [N_CH-1:0]  stable, rise;
   logic [N_CH-1:0]  press_q;
   logic [N_CH-1:0]  state_q, state_d;
   logic [N_CH-1:0]  led_q, led_d;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic             blk_phase_q, blk_phase_d;
   logic [CNT_W-1:0] total_q, total_d, inc;
   logic [1:0]       ch_mode;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      btn_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .raw_i        (btn_i[g]),
         .stable_o     (stable[g]),
         .rise_pulse_o (rise[g])
      );
   end

`ifdef BTN_LONG_PRESS_EN
   localparam int HOLD_W = $clog2(LONG_CYC + 1);
   logic [N_CH-1:0][HOLD_W-1:0] hold_q, hold_d;
   logic [N_CH-1:0]             long_q, long_d;
`endif

   always_comb begin
      blk_cnt_d   = blk_cnt_q + 1'b1;
      blk_phase_d = blk_phase_q;
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
         blk_cnt_d   = '0;
         blk_phase_d = ~blk_phase_q;
      end

      inc = '0;
      for (int i = 0; i < N_CH; i++) begin
         inc = inc + CNT_W'(press_q[i]);
      end
      total_d = total_q + inc;

      ch_mode = MODE_TOGGLE;
      state_d = state_q;
      led_d   = '0;
`ifdef BTN_LONG_PRESS_EN
      hold_d  = '0;
      long_d  = '0;
`endif
      for (int i = 0; i < N_CH; i++) begin
         ch_mode = mode_i[2*i +: 2];
         if (press_q[i] && mode_toggles(ch_mode)) begin
            state_d[i] = ~state_q[i];
         end
`ifdef BTN_LONG_PRESS_EN
         // Saturating hold counter: the pulse fires once on the step into LONG_CYC.
         if (stable[i]) begin
            hold_d[i] = hold_q[i];
            if (hold_q[i] != HOLD_W'(LONG_CYC)) begin
               hold_d[i] = hold_q[i] + 1'b1;
               if (hold_q[i] == HOLD_W'(LONG_CYC - 1)) begin
                  long_d[i]  = 1'b1;
                  state_d[i] = 1'b0;
               end
            end
         end
`endif
         case (ch_mode)
            MODE_TOGGLE: led_d[i] = state_d[i];
            MODE_MOM:    led_d[i] = stable[i];
            MODE_BLINK:  led_d[i] = state_d[i] & blk_phase_d;
            default:     led_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         press_q     <= '0;
         state_q     <= '0;
         led_q       <= '0;
         blk_cnt_q   <= '0;
         blk_phase_q <= 1'b0;
         total_q     <= '0;
      end else begin
         press_q     <= rise;
         state_q     <= state_d;
         led_q       <= led_d;
         blk_cnt_q   <= blk_cnt_d;
         blk_phase_q <= blk_phase_d;
         total_q     <= total_d;
      end
   end

`ifdef BTN_LONG_PRESS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q <= '0;
         long_q <= '0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end
   assign long_press_o = long_q;
`else
   assign long_press_o = '0;
`endif

   assign led_o         = led_q;
   assign press_o       = press_q;
   assign press_total_o = total_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl with small timing parameters (DB=4, BLINK=8, LONG=32, CNT_W=4).
module tb_btn_led_ctrl;

   localparam int N_CH = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_CH-1:0]  btn;
   logic [2*N_CH-1:0] mode;
   logic [N_CH-1:0]  led, press, long_press;
   logic [CNT_W-1:0] total;

   int n_total = 0;
   int n_bad   = 0;
   int long_cnt = 0;
   int k;
   int pcnt;
   logic seen;

   always #5 clk = ~clk;

   btn_led_ctrl #(
      .N_CH      (N_CH),
      .DB_CYCLES (4),
      .BLINK_DIV (8),
      .LONG_CYC  (32),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .btn_i         (btn),
      .mode_i        (mode),
      .led_o         (led),
      .press_o       (press),
      .long_press_o  (long_press),
      .press_total_o (total)
   );

   always @(negedge clk) begin
      if (rst === 1'b0 && long_press !== 4'b0000) long_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; btn = '0; mode = '0;

      // reset
      tick(1);
      check("rst_led", led, 0);
      check("rst_press", press, 0);
      check("rst_total", total, 0);
      tick(2);
      check("rst_led_end", led, 0);
      check("rst_total_end", total, 0);
      rst = 1'b0;
      tick(1);
      check("post_rst_press", press, 0);
      check("post_rst_led", led, 0);

      // toggle on ch0: press visible 7 edges after the raw rise
      btn = 4'b0001;
      tick(6);
      check("t2_early", press, 0);
      tick(1);
      check("t2_press", press, 4'b0001);
      tick(1);
      check("t2_once", press, 0);
      check("t2_led_on", led, 4'b0001);
      check("t2_total", total, 1);
      tick(12);
      check("t2_hold_nopulse", press, 0);
      btn = 4'b0000;
      tick(10);
      check("t2_release_led", led, 4'b0001);
      check("t2_release_total", total, 1);
      btn = 4'b0001;
      tick(7);
      check("t2_press2", press, 4'b0001);
      tick(1);
      check("t2_led_off", led, 4'b0000);
      check("t2_total2", total, 2);
      btn = 4'b0000;
      tick(10);

      // 3-cycle glitch on ch1 must be rejected
      btn = 4'b0010; seen = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (i == 3) btn = 4'b0000;
         tick(1);
         if (press[1] !== 1'b0) seen = 1'b1;
      end
      check("t3_glitch_nopress", seen, 0);
      check("t3_glitch_led", led, 4'b0000);
      check("t3_glitch_total", total, 2);

      // 4-cycle pulse on ch1 is exactly long enough
      btn = 4'b0010; pcnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) btn = 4'b0000;
         tick(1);
         if (press[1] === 1'b1) pcnt++;
      end
      check("t3_edge_press", pcnt, 1);
      check("t3_edge_led", led, 4'b0010);
      check("t3_edge_total", total, 3);

      // momentary on ch2
      mode = 8'h10;
      btn = 4'b0100;
      tick(6);
      check("t4_mom_lag", led, 4'b0010);
      tick(1);
      check("t4_mom_on", led, 4'b0110);
      check("t4_mom_press", press, 4'b0100);
      tick(1);
      check("t4_mom_total", total, 4);
      tick(10);
      btn = 4'b0000;
      tick(6);
      check("t4_mom_rel_lag", led, 4'b0110);
      tick(1);
      check("t4_mom_off", led, 4'b0010);

      // blink on ch3
      mode = 8'h90;
      btn = 4'b1000;
      tick(8);
      check("t4_blink_total", total, 5);
      btn = 4'b0000;
      tick(10);
      k = 0;
      while (led[3] !== 1'b0 && k < 20) begin tick(1); k++; end
      while (led[3] !== 1'b1 && k < 40) begin tick(1); k++; end
      check("t4_blink_rise", led[3], 1);
      tick(7);
      check("t4_blink_hi", led[3], 1);
      tick(1);
      check("t4_blink_fall", led[3], 0);
      tick(7);
      check("t4_blink_lo", led[3], 0);
      tick(1);
      check("t4_blink_rise2", led[3], 1);
      mode = 8'hD0;
      tick(1);
      check("t4_off_now", led[3], 0);
      mode = 8'h10;
      tick(1);
      check("t4_state_kept", led, 4'b1010);

      // bring the count to 14 with LEDs forced off
      mode = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         btn = 4'b0001;
         tick(8);
         btn = 4'b0000;
         tick(8);
      end
      check("t5_pre_total", total, 14);
      check("t5_off_led", led, 4'b0000);
      mode = 8'h00;
      tick(1);
      check("t5_restore_led", led, 4'b1010);
      btn = 4'b1111;
      tick(7);
      check("t5_all_press", press, 4'b1111);
      tick(1);
      check("t5_wrap_total", total, 2);
      check("t5_all_led", led, 4'b0101);
      btn = 4'b0000;
      tick(10);

      // long hold on ch0 in momentary mode, state 1 beforehand
      mode = 8'h01;
      btn = 4'b0001;
      tick(37);
      check("t6_long_early", long_press, 0);
      tick(1);
`ifdef BTN_LONG_PRESS_EN
      check("t6_long_pulse", long_press, 4'b0001);
`else
      check("t6_long_none", long_press, 0);
`endif
      tick(2);
      btn = 4'b0000;
      tick(10);
      mode = 8'h00;
      tick(1);
      check("t6_total", total, 3);
`ifdef BTN_LONG_PRESS_EN
      check("t6_state_cleared", led, 4'b0100);
      check("t6_pulse_count", long_cnt, 1);
`else
      check("t6_state_kept", led, 4'b0101);
      check("t6_pulse_count", long_cnt, 0);
`endif

      // reset mid-debounce discards progress
      btn = 4'b0010;
      tick(4);
      rst = 1'b1;
      tick(1);
      check("t7_rst_press", press, 0);
      check("t7_rst_led", led, 0);
      check("t7_rst_total", total, 0);
      rst = 1'b0;
      tick(1);
      check("t7_after_rst", press, 0);
      tick(5);
      check("t7_held_early", press, 0);
      tick(1);
      check("t7_held_press", press, 4'b0010);
      btn = 4'b0000;
      tick(10);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
